// File: rtl/ber_exp_pkg.sv
// ber_exp_pkg: shared types and constants for the BerExp compare stage.
//   state_t    FSM encoding {IDLE, SHIFT, FETCH, OUT}
//   EXP_W      width of the ApproxExp value and of z
//   S_W        width of the incoming shift count
//   S_MAX      saturation limit for the shift count
//   BYTE_W     width of one random byte
//   sat_shift  clamps a shift count to 0..S_MAX as a 6-bit value
package ber_exp_pkg;

  localparam int EXP_W  = 64;
  localparam int S_W    = 32;
  localparam int BYTE_W = 8;
  localparam logic [S_W-1:0] S_MAX = 32'd63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FETCH = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic logic [5:0] sat_shift(input logic [S_W-1:0] s);
    return (s > S_MAX) ? S_MAX[5:0] : s[5:0];
  endfunction

endpackage

// File: rtl/ber_exp_compare.sv
// ber_exp_compare: last stage of BerExp. Takes shift count s and the ApproxExp
// value, forms z = ((exp_in << 1) - 1) >> min(s,63), then compares random bytes
// MSB-first against z and returns b = (first differing random byte < z byte).
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_stb/in_ack         s/exp_in handshake (accepted only in IDLE)
//   s [S_W-1:0]           shift count from the s/r stage
//   exp_in [EXP_W-1:0]    ApproxExp result
//   rand_stb/rand_ack     random byte handshake (accepted only in FETCH)
//   rand_byte [7:0]       random byte from the PRNG
//   b, b_stb/b_ack        Bernoulli result and its handshake
//   byte_cnt [3:0]        bytes consumed for this result, present only when
//                         BER_EXP_CMP_BYTECNT_EN is defined
//
// State   | meaning
// IDLE    | waiting for s/exp_in, in_ack high
// SHIFT   | one cycle building z, byte index set to 7
// FETCH   | consuming random bytes MSB-first, rand_ack high
// OUT     | b_stb high with b held until b_ack
module ber_exp_compare
  import ber_exp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_stb,
  output logic             in_ack,
  input  logic [S_W-1:0]   s,
  input  logic [EXP_W-1:0] exp_in,
  input  logic             rand_stb,
  output logic             rand_ack,
  input  logic [7:0]       rand_byte,
  output logic             b,
  output logic             b_stb,
  input  logic             b_ack
`ifdef BER_EXP_CMP_BYTECNT_EN
  ,
  output logic [3:0]       byte_cnt
`endif
);

  state_t             state, state_nxt;
  logic [5:0]         s_sat;
  logic [EXP_W-1:0]   exp_r;
  logic [EXP_W-1:0]   z;
  logic [2:0]         i;
  logic [BYTE_W-1:0]  zb;
  logic               in_take;
  logic               rand_take;
  logic               byte_ne;

  assign zb        = z[{i, 3'b000} +: BYTE_W];
  assign in_take   = (state == IDLE) && in_stb;
  assign rand_take = (state == FETCH) && rand_stb;
  assign byte_ne   = (rand_byte != zb);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ack    = 1'b0;
    rand_ack  = 1'b0;
    b_stb     = 1'b0;
    case (state)
      IDLE: begin
        in_ack = 1'b1;
        if (in_stb) state_nxt = SHIFT;
      end
      SHIFT: state_nxt = FETCH;
      FETCH: begin
        rand_ack = 1'b1;
        if (rand_stb && (byte_ne || (i == 3'd0))) state_nxt = OUT;
      end
      OUT: begin
        b_stb = 1'b1;
        if (b_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_sat <= '0;
      exp_r <= '0;
      z     <= '0;
      i     <= '0;
      b     <= 1'b0;
    end else begin
      if (in_take) begin
        s_sat <= sat_shift(s);
        exp_r <= exp_in;
      end
      if (state == SHIFT) begin
        // modulo 2^64: exp_r MSB falls off, exp_r == 0 wraps to all-ones
        z <= ((exp_r << 1) - 64'd1) >> s_sat;
        i <= 3'd7;
      end
      if (rand_take) begin
        if (byte_ne)          b <= (rand_byte < zb);
        else if (i == 3'd0)   b <= 1'b0;
        else                  i <= i - 3'd1;
      end
    end
  end

`ifdef BER_EXP_CMP_BYTECNT_EN
  always_ff @(posedge clk) begin
    if (rst || in_take) byte_cnt <= '0;
    else if (rand_take) byte_cnt <= byte_cnt + 4'd1;
  end
`else
  // byte counter not built
`endif

endmodule

// File: tb/tb_ber_exp_compare.sv
module tb_ber_exp_compare;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_stb = 1'b0;
  logic        in_ack;
  logic [31:0] s = '0;
  logic [63:0] exp_in = '0;
  logic        rand_stb = 1'b0;
  logic        rand_ack;
  logic [7:0]  rand_byte = '0;
  logic        b;
  logic        b_stb;
  logic        b_ack = 1'b0;
`ifdef BER_EXP_CMP_BYTECNT_EN
  logic [3:0]  byte_cnt;
  logic [3:0]  bc_seen;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] rb [8];

  always #5 clk = ~clk;

  ber_exp_compare dut (
    .clk(clk), .rst(rst),
    .in_stb(in_stb), .in_ack(in_ack), .s(s), .exp_in(exp_in),
    .rand_stb(rand_stb), .rand_ack(rand_ack), .rand_byte(rand_byte),
    .b(b), .b_stb(b_stb), .b_ack(b_ack)
`ifdef BER_EXP_CMP_BYTECNT_EN
    , .byte_cnt(byte_cnt)
`endif
  );

  // random bytes in presentation order, first byte in the top 8 bits
  task automatic load_rb(input logic [63:0] v);
    for (int k = 0; k < 8; k++) rb[k] = v[63-8*k -: 8];
  endtask

  // lat counts cycles with the input transfer cycle as cycle 0
  task automatic run_op(input logic [31:0] sv, input logic [63:0] ev,
                        input int stall_at, input int ack_delay,
                        output logic bo, output int nb, output int lat,
                        output logic tmo, output logic hold_ok);
    int c;
    int stalled;
    logic took;
    tmo = 1'b0; hold_ok = 1'b1; nb = 0; lat = 0; bo = 1'b0; c = 0; stalled = 0;
    while (!in_ack && c < 20) begin @(posedge clk); #1; c++; end
    if (!in_ack) tmo = 1'b1;
    s = sv; exp_in = ev; in_stb = 1'b1;
    @(posedge clk); #1;
    in_stb = 1'b0; s = '0; exp_in = '0;
    c = 0;
    while (!b_stb && c < 100) begin
      rand_stb = 1'b0;
      if (rand_ack) begin
        if (nb == stall_at && stalled < 3) stalled++;
        else begin
          rand_stb  = 1'b1;
          rand_byte = (nb < 8) ? rb[nb] : 8'h00;
        end
      end
      took = rand_stb && rand_ack;
      @(posedge clk); #1;
      if (took) nb++;
      c++;
    end
    rand_stb = 1'b0;
    if (!b_stb) tmo = 1'b1;
    lat = c + 1;
    bo  = b;
`ifdef BER_EXP_CMP_BYTECNT_EN
    bc_seen = byte_cnt;
`endif
    for (int k = 0; k < ack_delay; k++) begin
      @(posedge clk); #1;
      if (b_stb !== 1'b1 || b !== bo || in_ack !== 1'b0 || rand_ack !== 1'b0) hold_ok = 1'b0;
    end
    b_ack = 1'b1;
    @(posedge clk); #1;
    b_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (in_ack !== 1'b1) $display("FAIL reset_in_ack: got %b want 1", in_ack); else pass_cnt++;
    total_cnt++; if (rand_ack !== 1'b0) $display("FAIL reset_rand_ack: got %b want 0", rand_ack); else pass_cnt++;
    total_cnt++; if (b_stb !== 1'b0) $display("FAIL reset_b_stb: got %b want 0", b_stb); else pass_cnt++;
    total_cnt++; if (b !== 1'b0) $display("FAIL reset_b: got %b want 0", b); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vector(input string name, input logic [31:0] sv, input logic [63:0] ev,
                             input logic [63:0] bytes, input logic exp_b, input int exp_nb);
    logic bo, tmo, hold_ok;
    int nb, lat;
    load_rb(bytes);
    run_op(sv, ev, -1, 0, bo, nb, lat, tmo, hold_ok);
    total_cnt++; if (tmo !== 1'b0) $display("FAIL %s_timeout: got %b want 0", name, tmo); else pass_cnt++;
    total_cnt++; if (bo !== exp_b) $display("FAIL %s_b: got %b want %b", name, bo, exp_b); else pass_cnt++;
    total_cnt++; if (nb != exp_nb) $display("FAIL %s_bytes: got %0d want %0d", name, nb, exp_nb); else pass_cnt++;
    total_cnt++; if (lat != 2 + exp_nb) $display("FAIL %s_latency: got %0d want %0d", name, lat, 2 + exp_nb); else pass_cnt++;
    total_cnt++; if (in_ack !== 1'b1) $display("FAIL %s_in_ack_after: got %b want 1", name, in_ack); else pass_cnt++;
`ifdef BER_EXP_CMP_BYTECNT_EN
    total_cnt++; if (bc_seen != exp_nb[3:0]) $display("FAIL %s_byte_cnt: got %0d want %0d", name, bc_seen, exp_nb); else pass_cnt++;
`endif
  endtask

  task automatic test_basic();
    test_vector("s0_full",   32'd0,   64'h8000_0000_0000_0000, 64'h12_55_55_55_55_55_55_55, 1'b1, 1);
    test_vector("s100_lt",   32'd100, 64'h8000_0000_0000_0000, 64'h00_00_00_00_00_00_00_00, 1'b1, 8);
    test_vector("s100_eq",   32'd100, 64'h8000_0000_0000_0000, 64'h00_00_00_00_00_00_00_01, 1'b0, 8);
    test_vector("s8_zero",   32'd8,   64'h0,                   64'h00_FE_55_55_55_55_55_55, 1'b1, 2);
    test_vector("s4_gt",     32'd4,   64'h4000_0000_0000_0000, 64'h08_55_55_55_55_55_55_55, 1'b0, 1);
    test_vector("s100_gt2",  32'd100, 64'h8000_0000_0000_0000, 64'h00_05_55_55_55_55_55_55, 1'b0, 2);
  endtask

  task automatic test_backpressure();
    logic bo, tmo, hold_ok;
    int nb, lat;
    load_rb(64'h00_FE_55_55_55_55_55_55);
    run_op(32'd8, 64'h0, 1, 5, bo, nb, lat, tmo, hold_ok);
    total_cnt++; if (tmo !== 1'b0) $display("FAIL bp_timeout: got %b want 0", tmo); else pass_cnt++;
    total_cnt++; if (bo !== 1'b1) $display("FAIL bp_b: got %b want 1", bo); else pass_cnt++;
    total_cnt++; if (nb != 2) $display("FAIL bp_bytes: got %0d want 2", nb); else pass_cnt++;
    total_cnt++; if (lat != 7) $display("FAIL bp_latency: got %0d want 7", lat); else pass_cnt++;
    total_cnt++; if (hold_ok !== 1'b1) $display("FAIL bp_out_hold: got %b want 1", hold_ok); else pass_cnt++;
    total_cnt++; if (in_ack !== 1'b1) $display("FAIL bp_in_ack_after: got %b want 1", in_ack); else pass_cnt++;
  endtask

  task automatic test_reset_mid_fetch();
    int nb, c;
    logic took;
    nb = 0; c = 0;
    load_rb(64'h0);
    s = 32'd100; exp_in = 64'h8000_0000_0000_0000; in_stb = 1'b1;
    @(posedge clk); #1;
    in_stb = 1'b0;
    while (nb < 2 && c < 20) begin
      rand_stb = rand_ack;
      rand_byte = 8'h00;
      took = rand_stb && rand_ack;
      @(posedge clk); #1;
      if (took) nb++;
      c++;
    end
    rand_stb = 1'b0;
    total_cnt++; if (nb != 2) $display("FAIL rstmid_bytes_before: got %0d want 2", nb); else pass_cnt++;
    total_cnt++; if (rand_ack !== 1'b1) $display("FAIL rstmid_in_fetch: got rand_ack %b want 1", rand_ack); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (in_ack !== 1'b1) $display("FAIL rstmid_in_ack: got %b want 1", in_ack); else pass_cnt++;
    total_cnt++; if (rand_ack !== 1'b0) $display("FAIL rstmid_rand_ack: got %b want 0", rand_ack); else pass_cnt++;
    total_cnt++; if (b_stb !== 1'b0) $display("FAIL rstmid_b_stb: got %b want 0", b_stb); else pass_cnt++;
    total_cnt++; if (b !== 1'b0) $display("FAIL rstmid_b: got %b want 0", b); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (rand_ack !== 1'b0) $display("FAIL rstmid_rand_ack_after: got %b want 0", rand_ack); else pass_cnt++;
    test_vector("post_rst", 32'd0, 64'h8000_0000_0000_0000, 64'h12_55_55_55_55_55_55_55, 1'b1, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ber_exp_compare.md
Name: ber_exp_compare

Overview:
- Final stage of the BerExp datapath. Sits directly downstream of the s/r decomposition stage and the ApproxExp stage.
- Consumes the shift count s and the 64-bit ApproxExp result.
- Forms z = ((exp_in << 1) - 1) >> min(s,63), then draws random bytes MSB-first and compares them against the bytes of z.
- Emits the Bernoulli bit b = (first non-equal random byte < z byte), as in FALCON BerExp.

Parameters:
- EXP_W, 64, width of exp_in and z.
- S_W, 32, width of s input.
- S_MAX, 63, saturation limit for the shift count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_stb  in  1  s/exp_in valid.
- in_ack  out  1  block ready to accept s/exp_in.
- s  in  S_W  unsigned shift count from the s/r stage.
- exp_in  in  EXP_W  ApproxExp result (unsigned fixed point).
- rand_stb  in  1  random byte valid.
- rand_ack  out  1  block ready to take a random byte.
- rand_byte  in  8  random byte from the PRNG.
- b  out  1  Bernoulli result.
- b_stb  out  1  b valid.
- b_ack  in  1  downstream ready for b.

Behaviour:
- Handshakes: a transfer occurs on a rising edge where stb and ack are both high. Data must stay stable while stb is high without ack.
- Reset values: in_ack=1, rand_ack=0, b=0, b_stb=0, state=IDLE. Internal z, i and s_sat are cleared.
- IDLE: in_ack=1.
  - On in_stb&&in_ack, register s_sat = (s > S_MAX) ? S_MAX : s[5:0], and register exp_in.
  - Go to SHIFT.
- SHIFT (1 cycle): z <= ((exp_in << 1) - 1) >> s_sat.
  - Arithmetic is modulo 2^64: the MSB of exp_in is discarded, and exp_in=0 yields all-ones before the shift.
  - i <= 7 (byte index, 7 = bits 63:56). Go to FETCH.
- FETCH: rand_ack=1. On each rand_stb&&rand_ack, compare rand_byte with zb = z[8*i+7 : 8*i].
  - rand_byte != zb: b <= (rand_byte < zb). Go to OUT.
  - Equal and i==0: b <= 0. Go to OUT.
  - Equal and i>0: i <= i-1. Stay in FETCH.
- OUT: b_stb=1 with b stable, rand_ack=0, in_ack=0. On b_ack, go to IDLE. in_ack reasserts on the next cycle.
- Random byte consumption: 1 to 8 bytes per result. No bytes are consumed outside FETCH.
- Latency with no stalls: accept -> SHIFT -> first FETCH cycle. b_stb rises 2 + (bytes consumed) cycles after the input transfer.
- Only one operation is in flight. in_stb is ignored outside IDLE.
- Reset asserted in any state returns all outputs to reset values on the next edge. A partial byte sequence is abandoned, and no further rand_ack is issued.

Optional Feature:
- Macro BER_EXP_CMP_BYTECNT_EN.
- When defined: extra output port byte_cnt [3:0].
  - Holds the number of random bytes consumed for the current result (1..8).
  - Valid while b_stb=1. Cleared by reset and on input accept.
- When undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package ber_exp_pkg holds:
  - the state enum {IDLE, SHIFT, FETCH, OUT};
  - constants EXP_W, S_MAX and BYTE_W=8;
  - a function sat_shift(s) returning 6 bits.
- No sub-module. A single FSM plus datapath is natural.

Test Plan:
- s=0, exp_in=0x8000_0000_0000_0000 -> z=0xFFFF_FFFF_FFFF_FFFF. rand_byte 0x12 -> b=1 after 1 byte.
- s=100 (saturates to 63), exp_in=0x8000_0000_0000_0000 -> z=1.
  - Eight bytes 0x00 -> last compare 0x00<0x01 -> b=1 after 8 bytes.
  - Repeat with last byte 0x01 -> b=0 after 8 bytes.
- s=8, exp_in=0 -> z=0x00FF_FFFF_FFFF_FFFF. Bytes 0x00, 0xFE -> b=1 after 2 bytes.
- s=4, exp_in=0x4000_0000_0000_0000 -> z=0x07FF_FFFF_FFFF_FFFF. Byte 0x08 -> b=0 after 1 byte.
- Backpressure: hold b_ack=0 for 5 cycles and rand_stb low for 3 cycles mid-FETCH.
  - b_stb and b hold stable, in_ack=0, rand_ack=0 in OUT.
  - Result is unchanged versus the no-stall run.
- Reset asserted during FETCH after 2 bytes -> next cycle in_ack=1, rand_ack=0, b_stb=0. A fresh vector then completes correctly.
